// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to a PS/2 device over the shared open-drain
// PS2_CLK/PS2_DAT lines and reports acknowledge, timeout or completion.
// The enclosing level wires each line as drive_low ? 0 : z.
//
// Ports:
//   CLOCK_50           in   system clock (50 MHz)
//   reset_n            in   asynchronous active-low reset
//   send               in   start request, sampled only when idle
//   tx_data[7:0]       in   command byte, latched on an accepted send
//   ps2_clk_in         in   raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in         in   raw PS2_DAT pin level (asynchronous)
//   ps2_clk_drive_low  out  1 pulls PS2_CLK low
//   ps2_dat_drive_low  out  1 pulls PS2_DAT low
//   busy               out  high from accept until done
//   done               out  one-cycle pulse ending every transaction
//   ack_ok             out  device pulled DAT low at the ACK clock
//   error              out  a timeout ended the transaction
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned START_TIMEOUT  = 750000,
  parameter int unsigned FRAME_TIMEOUT  = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  // Data is put on the line one cycle before the clock is released, so the
  // start bit is already valid when the device sees CLK go high.
  localparam logic [19:0] INHIBIT_DAT  = 20'(INHIBIT_CYCLES - 32'd2);
  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 32'd1);
  localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 32'd1);
  localparam logic [19:0] FRAME_LAST   = 20'(FRAME_TIMEOUT - 32'd1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    RTS      = 3'd2,
    SHIFT    = 3'd3,
    ACK      = 3'd4,
    WAITIDLE = 3'd5,
    FIN      = 3'd6,
    ERR      = 3'd7
  } state_t;

  // Odd parity bit over the command byte.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t      state_r;
  logic [1:0]  clk_sync_r;
  logic [1:0]  dat_sync_r;
  logic        clk_prev_r;
  logic [19:0] cnt_r;
  logic [3:0]  idx_r;
  logic [9:0]  shreg_r;
  logic        fall_s;
  logic [19:0] cnt_inc_s;

  // Synchronise both pins and keep the previous synced CLK for edge detect.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r <= 2'b11;
      dat_sync_r <= 2'b11;
      clk_prev_r <= 1'b1;
    end else begin
      clk_sync_r <= {clk_sync_r[0], ps2_clk_in};
      dat_sync_r <= {dat_sync_r[0], ps2_dat_in};
      clk_prev_r <= clk_sync_r[1];
    end
  end

  assign fall_s    = clk_prev_r & ~clk_sync_r[1];
  // Counter saturates instead of wrapping so a stuck state never re-arms.
  assign cnt_inc_s = (cnt_r == 20'hF_FFFF) ? cnt_r : cnt_r + 20'd1;

  // Transaction state machine with registered line drives and status.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r           <= IDLE;
      cnt_r             <= 20'd0;
      idx_r             <= 4'd0;
      shreg_r           <= 10'd0;
      ps2_clk_drive_low <= 1'b0;
      ps2_dat_drive_low <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      ack_ok            <= 1'b0;
      error             <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          done              <= 1'b0;
          if (send) begin
            shreg_r           <= {1'b1, odd_parity(tx_data), tx_data};
            idx_r             <= 4'd0;
            cnt_r             <= 20'd0;
            ack_ok            <= 1'b0;
            error             <= 1'b0;
            busy              <= 1'b1;
            ps2_clk_drive_low <= 1'b1;
            state_r           <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Device clock edges are ignored here: the host owns CLK.
          cnt_r <= cnt_inc_s;
          if (cnt_r == INHIBIT_DAT) begin
            ps2_dat_drive_low <= 1'b1;
          end
          if (cnt_r == INHIBIT_LAST) begin
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b1;
            cnt_r             <= 20'd0;
            state_r           <= RTS;
          end
        end
        RTS: begin
          // The first device fall clocks out the start bit already on DAT.
          if (fall_s) begin
            cnt_r   <= 20'd0;
            idx_r   <= 4'd0;
            state_r <= SHIFT;
          end else if (cnt_r >= START_LAST) begin
            state_r <= ERR;
          end else begin
            cnt_r <= cnt_inc_s;
          end
        end
        SHIFT: begin
          cnt_r <= cnt_inc_s;
          if (cnt_r >= FRAME_LAST) begin
            state_r <= ERR;
          end else if (fall_s) begin
            ps2_dat_drive_low <= ~shreg_r[idx_r];
            if (idx_r == 4'd9) begin
              state_r <= ACK;
            end else begin
              idx_r <= idx_r + 4'd1;
            end
          end
        end
        ACK: begin
          cnt_r <= cnt_inc_s;
          if (cnt_r >= FRAME_LAST) begin
            state_r <= ERR;
          end else if (fall_s) begin
            ack_ok  <= ~dat_sync_r[1];
            state_r <= WAITIDLE;
          end
        end
        WAITIDLE: begin
          cnt_r <= cnt_inc_s;
          if (cnt_r >= FRAME_LAST) begin
            state_r <= ERR;
          end else if (clk_sync_r[1] && dat_sync_r[1]) begin
            state_r <= FIN;
          end
        end
        FIN: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          done              <= 1'b1;
          busy              <= 1'b0;
          state_r           <= IDLE;
        end
        ERR: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          error             <= 1'b1;
          ack_ok            <= 1'b0;
          state_r           <= FIN;
        end
        default: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          done              <= 1'b0;
          state_r           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a keyboard model clocks frames out of the host,
// expected outcomes are queued per transaction and checked when done pulses.
module tb_ps2_host_tx;

  localparam int INHIB   = 20;
  localparam int START_TO = 200;
  localparam int FRAME_TO = 2000;
  localparam int HALF    = 40;
  localparam int KB_DELAY = 30;

  logic       CLOCK_50;
  logic       reset_n;
  logic       send;
  logic [7:0] tx_data;
  logic       ps2_clk;
  logic       ps2_dat;
  logic       ps2_clk_drive_low;
  logic       ps2_dat_drive_low;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;

  logic       kb_clk_low;
  logic       kb_dat_low;
  int         kb_mode;   // 0 ack, 1 silent, 2 stall after bit 4, 3 nack
  logic       kb_abort;
  logic [10:0] rx_bits;
  int         rx_cnt;

  int checks;
  int failures;
  int cyc;
  int done_cnt;
  int acc_cyc;

  typedef struct {
    logic        ack;
    logic        err;
    logic        chk_frame;
    logic [10:0] frame;
    int          acc;
    int          lat_lo;
    int          lat_hi;
  } exp_t;

  exp_t exp_q[$];

  assign ps2_clk = ~(ps2_clk_drive_low | kb_clk_low);
  assign ps2_dat = ~(ps2_dat_drive_low | kb_dat_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIB),
    .START_TIMEOUT (START_TO),
    .FRAME_TIMEOUT (FRAME_TO)
  ) dut (
    .CLOCK_50         (CLOCK_50),
    .reset_n          (reset_n),
    .send             (send),
    .tx_data          (tx_data),
    .ps2_clk_in       (ps2_clk),
    .ps2_dat_in       (ps2_dat),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_dat_drive_low(ps2_dat_drive_low),
    .busy             (busy),
    .done             (done),
    .ack_ok           (ack_ok),
    .error            (error)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Reference frame as the device should see it: start, data LSB first,
  // odd parity (bit set when the byte has an even number of ones), stop.
  function automatic logic [10:0] ref_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = ((ones % 2) == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Keyboard model: answers a request-to-send by generating clocks and
  // sampling DAT on each CLK rise.
  initial begin : kb_model
    kb_clk_low = 1'b0;
    kb_dat_low = 1'b0;
    rx_bits    = '0;
    rx_cnt     = 0;
    forever begin
      @(negedge ps2_clk_drive_low);
      if (ps2_dat_drive_low && kb_mode != 1) begin
        rx_bits = '0;
        rx_cnt  = 0;
        repeat (KB_DELAY) @(negedge CLOCK_50);
        for (int k = 0; k < 12; k++) begin
          kb_clk_low = 1'b1;
          repeat (HALF) @(negedge CLOCK_50);
          if (kb_abort) break;
          kb_clk_low = 1'b0;
          if (k <= 10) begin
            rx_bits[k] = ps2_dat;
            rx_cnt     = k + 1;
          end
          if (k == 10 && kb_mode == 0) kb_dat_low = 1'b1;
          if (k == 11) kb_dat_low = 1'b0;
          if (kb_mode == 2 && k == 5) break;
          repeat (HALF) @(negedge CLOCK_50);
          if (kb_abort) break;
        end
        kb_clk_low = 1'b0;
        kb_dat_low = 1'b0;
      end
    end
  end

  // Monitor: pops the expected outcome on every done pulse.
  initial begin : monitor
    exp_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (done) begin
        done_cnt++;
        checks++;
        if (done_prev) begin
          failures++;
          $display("FAIL done_width actual=2+ cycles required=1");
        end
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("ack_ok", int'(ack_ok), int'(e.ack));
          check("error", int'(error), int'(e.err));
          check("busy_at_done", int'(busy), 0);
          check("drives_at_done", int'({ps2_clk_drive_low, ps2_dat_drive_low}), 0);
          checks++;
          if ((cyc - e.acc) < e.lat_lo || (cyc - e.acc) > e.lat_hi) begin
            failures++;
            $display("FAIL done_latency actual=%0d required=%0d..%0d",
                     cyc - e.acc, e.lat_lo, e.lat_hi);
          end
          if (e.chk_frame) begin
            check("frame_bits", int'(rx_bits), int'(e.frame));
            check("frame_len", rx_cnt, 11);
          end
        end
      end
      done_prev = done;
    end
  end

  // Inhibit shape: CLK held INHIB cycles, DAT low only in the last of them.
  initial begin : line_timing
    int clk_hi;
    int dat_hi;
    logic clk_prev;
    clk_hi   = 0;
    dat_hi   = 0;
    clk_prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        clk_hi = 0;
        dat_hi = 0;
      end else if (ps2_clk_drive_low) begin
        clk_hi++;
        if (ps2_dat_drive_low) dat_hi++;
      end else if (clk_prev) begin
        check("clk_inhibit_len", clk_hi, INHIB);
        check("dat_lead", dat_hi, 1);
        clk_hi = 0;
        dat_hi = 0;
      end
      clk_prev = ps2_clk_drive_low;
    end
  end

  task automatic do_send(input logic [7:0] d);
    @(negedge CLOCK_50);
    send    = 1'b1;
    tx_data = d;
    @(negedge CLOCK_50);
    send    = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic push_exp(input logic a, input logic er, input logic chk,
                          input logic [7:0] d, input int lo, input int hi);
    exp_t e;
    e.ack       = a;
    e.err       = er;
    e.chk_frame = chk;
    e.frame     = ref_frame(d);
    e.acc       = acc_cyc;
    e.lat_lo    = lo;
    e.lat_hi    = hi;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int limit);
    int start;
    start = done_cnt;
    for (int i = 0; i < limit && done_cnt == start; i++) @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if (done_cnt == start) begin
      failures++;
      $display("FAIL %s_timeout actual=no done required=done within %0d cycles", name, limit);
    end
  endtask

  task automatic normal_txn(input logic [7:0] d);
    kb_mode = 0;
    do_send(d);
    push_exp(1'b1, 1'b0, 1'b1, d, 0, 5000);
    wait_done("normal", 3000);
    repeat (100) @(negedge CLOCK_50);
  endtask

  initial begin : stimulus
    int start;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    done_cnt = 0;
    acc_cyc  = 0;
    kb_mode  = 0;
    kb_abort = 1'b0;
    reset_n  = 1'b0;
    send     = 1'b0;
    tx_data  = 8'h00;

    #55;
    check("rst_clk_drive", int'(ps2_clk_drive_low), 0);
    check("rst_dat_drive", int'(ps2_dat_drive_low), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ack", int'(ack_ok), 0);
    check("rst_error", int'(error), 0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);

    // Directed frames with known parity, then random bytes.
    normal_txn(8'hF4);
    normal_txn(8'hED);
    normal_txn(8'h01);
    for (int i = 0; i < 4; i++) normal_txn(8'($urandom_range(0, 255)));

    // Device never clocks: start timeout.
    kb_mode = 1;
    do_send(8'hF4);
    check("busy_after_accept", int'(busy), 1);
    push_exp(1'b0, 1'b1, 1'b0, 8'hF4, INHIB + START_TO - 3, INHIB + START_TO + 3);
    wait_done("start_to", 1000);
    repeat (100) @(negedge CLOCK_50);

    // Device stalls after data bit 4: frame timeout.
    kb_mode = 2;
    do_send(8'h5A);
    push_exp(1'b0, 1'b1, 1'b0, 8'h5A, INHIB + KB_DELAY + FRAME_TO - 8,
             INHIB + KB_DELAY + FRAME_TO + 8);
    wait_done("frame_to", 4000);
    check("busy_after_frame_to", int'(busy), 0);
    repeat (100) @(negedge CLOCK_50);

    // NACK, plus a send pulse while busy that must be ignored.
    kb_mode = 3;
    do_send(8'hFF);
    push_exp(1'b0, 1'b0, 1'b1, 8'hFF, 0, 5000);
    repeat (300) @(negedge CLOCK_50);
    send    = 1'b1;
    tx_data = 8'h33;
    @(negedge CLOCK_50);
    send    = 1'b0;
    wait_done("nack", 3000);
    start = done_cnt;
    repeat (400) @(negedge CLOCK_50);
    check("no_second_frame", done_cnt - start, 0);
    check("idle_after_nack", int'(busy), 0);
    check("nack_ack_held", int'(ack_ok), 0);

    // Reset in the middle of a frame.
    kb_mode = 0;
    do_send(8'hA5);
    for (int i = 0; i < 3000 && rx_cnt < 5; i++) @(negedge CLOCK_50);
    check("reached_shift", int'(rx_cnt >= 5), 1);
    #7;
    reset_n = 1'b0;
    #1;
    check("mid_rst_clk_drive", int'(ps2_clk_drive_low), 0);
    check("mid_rst_dat_drive", int'(ps2_dat_drive_low), 0);
    check("mid_rst_busy", int'(busy), 0);
    kb_abort = 1'b1;
    repeat (100) @(negedge CLOCK_50);
    reset_n  = 1'b1;
    kb_abort = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    normal_txn(8'hFF);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
